// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one external memory port between the fetch-stage requester (imem)
//   and the decode-stage requester (dmem). Each requester issues one-cycle
//   request pulses. Each requester has a one-entry pending slot. When both
//   requesters want the port, the grant alternates between them. The
//   response strobe goes back to the requester that owns the port.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   imem_valid          instruction-side request pulse
//   imem_instr/addr/wdata/wstrb   request fields (wstrb==0 means read)
//   imem_ready          one-cycle completion strobe
//   imem_rdata          read data (always mirrors mem_rdata)
//   dmem_*              same set for the data-side requester
//   mem_valid/instr/addr/wdata/wstrb   registered request to the memory port
//   mem_ready, mem_rdata               completion and read data from the port
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    imem_valid,
  input  logic                    imem_instr,
  input  logic [ADDR_WIDTH-1:0]   imem_addr,
  input  logic [DATA_WIDTH-1:0]   imem_wdata,
  input  logic [DATA_WIDTH/8-1:0] imem_wstrb,
  output logic                    imem_ready,
  output logic [DATA_WIDTH-1:0]   imem_rdata,
  input  logic                    dmem_valid,
  input  logic                    dmem_instr,
  input  logic [ADDR_WIDTH-1:0]   dmem_addr,
  input  logic [DATA_WIDTH-1:0]   dmem_wdata,
  input  logic [DATA_WIDTH/8-1:0] dmem_wstrb,
  output logic                    dmem_ready,
  output logic [DATA_WIDTH-1:0]   dmem_rdata,
  output logic                    mem_valid,
  output logic                    mem_instr,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_ready,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, SERV_I, SERV_D} state_t;

  state_t                  r_state;
  logic                    r_lastGrantD;

  // A pend bit means "buffered but not yet granted". It is cleared at grant
  // time, so a requester that is being served never counts as a candidate
  // unless it pulses again.
  logic                    r_iPend;
  logic                    r_iInstr;
  logic [ADDR_WIDTH-1:0]   r_iAddr;
  logic [DATA_WIDTH-1:0]   r_iWdata;
  logic [STRB_WIDTH-1:0]   r_iWstrb;

  logic                    r_dPend;
  logic                    r_dInstr;
  logic [ADDR_WIDTH-1:0]   r_dAddr;
  logic [DATA_WIDTH-1:0]   r_dWdata;
  logic [STRB_WIDTH-1:0]   r_dWstrb;

  logic                    r_memValid;
  logic                    r_memInstr;
  logic [ADDR_WIDTH-1:0]   r_memAddr;
  logic [DATA_WIDTH-1:0]   r_memWdata;
  logic [STRB_WIDTH-1:0]   r_memWstrb;

  logic                    w_iAccept;
  logic                    w_dAccept;
  logic                    w_iCand;
  logic                    w_dCand;
  logic                    w_decide;
  logic                    w_grantI;
  logic                    w_grantD;
  logic                    w_winInstr;
  logic [ADDR_WIDTH-1:0]   w_winAddr;
  logic [DATA_WIDTH-1:0]   w_winWdata;
  logic [STRB_WIDTH-1:0]   w_winWstrb;

  // A pulse is dropped while its slot is still waiting, or while its own
  // transaction is stalled. In the completion cycle the pulse is accepted as
  // a fresh request.
  assign w_iAccept = imem_valid && !r_iPend && !((r_state == SERV_I) && !mem_ready);
  assign w_dAccept = dmem_valid && !r_dPend && !((r_state == SERV_D) && !mem_ready);

  assign w_iCand  = r_iPend || w_iAccept;
  assign w_dCand  = r_dPend || w_dAccept;

  // The arbiter makes a decision in every IDLE cycle and in every
  // completion cycle. mem_ready is ignored while the port is in IDLE.
  assign w_decide = (r_state == IDLE) || mem_ready;

  // If both requesters are candidates, the one that was not granted last wins.
  assign w_grantI = w_decide && w_iCand && (!w_dCand || r_lastGrantD);
  assign w_grantD = w_decide && w_dCand && (!w_iCand || !r_lastGrantD);

  // Fields of the winner: taken from the slot if buffered, or from the live
  // inputs if the request arrives in the same cycle it is granted.
  always_comb begin
    w_winInstr = 1'b0;
    w_winAddr  = '0;
    w_winWdata = '0;
    w_winWstrb = '0;
    if (w_grantI) begin
      if (r_iPend) begin
        w_winInstr = r_iInstr;
        w_winAddr  = r_iAddr;
        w_winWdata = r_iWdata;
        w_winWstrb = r_iWstrb;
      end else begin
        w_winInstr = imem_instr;
        w_winAddr  = imem_addr;
        w_winWdata = imem_wdata;
        w_winWstrb = imem_wstrb;
      end
    end else if (w_grantD) begin
      if (r_dPend) begin
        w_winInstr = r_dInstr;
        w_winAddr  = r_dAddr;
        w_winWdata = r_dWdata;
        w_winWstrb = r_dWstrb;
      end else begin
        w_winInstr = dmem_instr;
        w_winAddr  = dmem_addr;
        w_winWdata = dmem_wdata;
        w_winWstrb = dmem_wstrb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_lastGrantD <= 1'b0;
      r_iPend      <= 1'b0;
      r_iInstr     <= 1'b0;
      r_iAddr      <= '0;
      r_iWdata     <= '0;
      r_iWstrb     <= '0;
      r_dPend      <= 1'b0;
      r_dInstr     <= 1'b0;
      r_dAddr      <= '0;
      r_dWdata     <= '0;
      r_dWstrb     <= '0;
      r_memValid   <= 1'b0;
      r_memInstr   <= 1'b0;
      r_memAddr    <= '0;
      r_memWdata   <= '0;
      r_memWstrb   <= '0;
    end else begin
      if (w_iAccept) begin
        r_iInstr <= imem_instr;
        r_iAddr  <= imem_addr;
        r_iWdata <= imem_wdata;
        r_iWstrb <= imem_wstrb;
      end
      if (w_dAccept) begin
        r_dInstr <= dmem_instr;
        r_dAddr  <= dmem_addr;
        r_dWdata <= dmem_wdata;
        r_dWstrb <= dmem_wstrb;
      end

      if (w_grantI) begin
        r_iPend <= 1'b0;
      end else if (w_iAccept) begin
        r_iPend <= 1'b1;
      end
      if (w_grantD) begin
        r_dPend <= 1'b0;
      end else if (w_dAccept) begin
        r_dPend <= 1'b1;
      end

      // Grants can run back-to-back. A stalled transaction keeps the mem_*
      // outputs unchanged because nothing below fires while mem_ready is low.
      if (w_grantI || w_grantD) begin
        r_memValid   <= 1'b1;
        r_memInstr   <= w_winInstr;
        r_memAddr    <= w_winAddr;
        r_memWdata   <= w_winWdata;
        r_memWstrb   <= w_winWstrb;
        r_state      <= w_grantI ? SERV_I : SERV_D;
        r_lastGrantD <= w_grantD;
      end else if ((r_state != IDLE) && mem_ready) begin
        r_memValid <= 1'b0;
        r_state    <= IDLE;
      end
    end
  end

  assign mem_valid  = r_memValid;
  assign mem_instr  = r_memInstr;
  assign mem_addr   = r_memAddr;
  assign mem_wdata  = r_memWdata;
  assign mem_wstrb  = r_memWstrb;

  assign imem_ready = (r_state == SERV_I) && mem_ready;
  assign dmem_ready = (r_state == SERV_D) && mem_ready;
  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Drives the arbiter with directed scenarios and then a randomized phase.
//   A transaction-level reference model runs in parallel with the DUT. It
//   uses per-requester wait queues, an owner index and the last winner.
module tb_mem_arbiter;

  typedef struct {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imemValid, imemInstr;
  logic [31:0] imemAddr, imemWdata;
  logic [3:0]  imemWstrb;
  logic        imemReady;
  logic [31:0] imemRdata;
  logic        dmemValid, dmemInstr;
  logic [31:0] dmemAddr, dmemWdata;
  logic [3:0]  dmemWstrb;
  logic        dmemReady;
  logic [31:0] dmemRdata;
  logic        memValid, memInstr;
  logic [31:0] memAddr, memWdata;
  logic [3:0]  memWstrb;
  logic        memReady;
  logic [31:0] memRdata;

  int checks = 0;
  int errors = 0;

  // Reference model state
  req_t qI[$];
  req_t qD[$];
  int   owner;
  bit   lastD;
  bit   eValid;
  req_t eReq;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .imem_valid(imemValid), .imem_instr(imemInstr), .imem_addr(imemAddr),
    .imem_wdata(imemWdata), .imem_wstrb(imemWstrb),
    .imem_ready(imemReady), .imem_rdata(imemRdata),
    .dmem_valid(dmemValid), .dmem_instr(dmemInstr), .dmem_addr(dmemAddr),
    .dmem_wdata(dmemWdata), .dmem_wstrb(dmemWstrb),
    .dmem_ready(dmemReady), .dmem_rdata(dmemRdata),
    .mem_valid(memValid), .mem_instr(memInstr), .mem_addr(memAddr),
    .mem_wdata(memWdata), .mem_wstrb(memWstrb),
    .mem_ready(memReady), .mem_rdata(memRdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output with the model's expectation for this cycle.
  task automatic checkModel();
    checkOutput("mem_valid", {63'd0, memValid}, {63'd0, eValid});
    checkOutput("mem_instr", {63'd0, memInstr}, {63'd0, eReq.instr});
    checkOutput("mem_addr", {32'd0, memAddr}, {32'd0, eReq.addr});
    checkOutput("mem_wdata", {32'd0, memWdata}, {32'd0, eReq.wdata});
    checkOutput("mem_wstrb", {60'd0, memWstrb}, {60'd0, eReq.wstrb});
    checkOutput("imem_ready", {63'd0, imemReady}, {63'd0, (owner == 0) && memReady});
    checkOutput("dmem_ready", {63'd0, dmemReady}, {63'd0, (owner == 1) && memReady});
    checkOutput("imem_rdata", {32'd0, imemRdata}, {32'd0, memRdata});
    checkOutput("dmem_rdata", {32'd0, dmemRdata}, {32'd0, memRdata});
  endtask

  // Advance the model by one clock edge, using the inputs of this cycle.
  task automatic modelStep();
    req_t r;
    int   pick;
    bit   canI, canD;
    if (!rst) begin
      qI.delete();
      qD.delete();
      owner  = -1;
      lastD  = 1'b0;
      eValid = 1'b0;
      eReq   = '{1'b0, 32'd0, 32'd0, 4'd0};
    end else begin
      canI = !(owner == 0 && !memReady);
      canD = !(owner == 1 && !memReady);
      if (imemValid && qI.size() == 0 && canI) begin
        r = '{imemInstr, imemAddr, imemWdata, imemWstrb};
        qI.push_back(r);
      end
      if (dmemValid && qD.size() == 0 && canD) begin
        r = '{dmemInstr, dmemAddr, dmemWdata, dmemWstrb};
        qD.push_back(r);
      end
      if (owner == -1 || memReady) begin
        pick = -1;
        if (qI.size() != 0 && qD.size() != 0) pick = lastD ? 0 : 1;
        else if (qI.size() != 0) pick = 0;
        else if (qD.size() != 0) pick = 1;
        if (pick == 0) eReq = qI.pop_front();
        if (pick == 1) eReq = qD.pop_front();
        if (pick >= 0) begin
          eValid = 1'b1;
          owner  = pick;
          lastD  = (pick == 1);
        end else begin
          eValid = 1'b0;
          owner  = -1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic dv, input logic mr, input logic [31:0] rd);
    imemValid = iv;
    dmemValid = dv;
    memReady  = mr;
    memRdata  = rd;
    #2;
    checkModel();
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic setI(input logic instr, input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
    imemInstr = instr; imemAddr = a; imemWdata = w; imemWstrb = s;
  endtask

  task automatic setD(input logic instr, input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
    dmemInstr = instr; dmemAddr = a; dmemWdata = w; dmemWstrb = s;
  endtask

  task automatic doReset();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int readyCount;
    rst = 1'b0;
    imemValid = 0; dmemValid = 0; memReady = 0; memRdata = 0;
    setI(1'b0, 0, 0, 0);
    setD(1'b0, 0, 0, 0);
    owner = -1; lastD = 0; eValid = 0; eReq = '{1'b0, 32'd0, 32'd0, 4'd0};
    modelStep();
    @(posedge clk);
    #1;
    doReset();

    // Reset values
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("reset_mem_valid", {63'd0, memValid}, 64'd0);
    checkOutput("reset_mem_addr", {32'd0, memAddr}, 64'd0);
    tick();

    // 1. Single read with a zero-wait memory
    $display("[TB] single read");
    setD(1'b0, 32'h100, 32'h0, 4'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    checkOutput("t1_mem_valid", {63'd0, memValid}, 64'd1);
    checkOutput("t1_mem_addr", {32'd0, memAddr}, 64'h100);
    checkOutput("t1_mem_instr", {63'd0, memInstr}, 64'd0);
    checkOutput("t1_dmem_ready", {63'd0, dmemReady}, 64'd1);
    checkOutput("t1_dmem_rdata", {32'd0, dmemRdata}, 64'hDEADBEEF);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("t1_mem_valid_low", {63'd0, memValid}, 64'd0);
    tick();

    // 2. Simultaneous pulses after reset: data side wins the first tie
    $display("[TB] simultaneous");
    doReset();
    setI(1'b1, 32'h0, 32'h0, 4'h0);
    setD(1'b0, 32'h200, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h11);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h22);
    checkOutput("t2_first_addr", {32'd0, memAddr}, 64'h200);
    checkOutput("t2_first_instr", {63'd0, memInstr}, 64'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h33);
    checkOutput("t2_second_valid", {63'd0, memValid}, 64'd1);
    checkOutput("t2_second_addr", {32'd0, memAddr}, 64'h0);
    checkOutput("t2_second_instr", {63'd0, memInstr}, 64'd1);
    tick();

    // 3. Alternation: completer re-pulses on each completion
    $display("[TB] alternation");
    doReset();
    setI(1'b1, 32'h40, 32'h0, 4'h0);
    setD(1'b0, 32'h240, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0);
    tick();
    for (int k = 1; k <= 6; k++) begin
      applyStimulus((k % 2 == 0) && (k <= 4), (k % 2 == 1) && (k <= 4), 1'b1, 32'(k));
      checkOutput("t3_valid", {63'd0, memValid}, 64'd1);
      checkOutput("t3_order", {63'd0, memInstr}, (k % 2 == 0) ? 64'd1 : 64'd0);
      tick();
    end

    // 4. Store with three wait states
    $display("[TB] store with wait states");
    doReset();
    setD(1'b0, 32'h304, 32'h12345678, 4'b1100);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    readyCount = 0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b0, k == 3, 32'h5A5A0000 + 32'(k));
      if (k < 4) begin
        checkOutput("t4_addr", {32'd0, memAddr}, 64'h304);
        checkOutput("t4_wdata", {32'd0, memWdata}, 64'h12345678);
        checkOutput("t4_wstrb", {60'd0, memWstrb}, 64'hC);
      end
      if (dmemReady) readyCount++;
      tick();
    end
    checkOutput("t4_ready_once", 64'(readyCount), 64'd1);

    // 5. Buffering behind a stalled data access
    $display("[TB] buffering");
    doReset();
    setD(1'b0, 32'h400, 32'h0, 4'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    setI(1'b1, 32'h80, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    setI(1'b1, 32'hBAD, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h77);
    checkOutput("t5_dmem_ready", {63'd0, dmemReady}, 64'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h88);
    checkOutput("t5_switch_addr", {32'd0, memAddr}, 64'h80);
    checkOutput("t5_imem_ready", {63'd0, imemReady}, 64'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h99);
    checkOutput("t5_no_second", {63'd0, memValid}, 64'd0);
    tick();

    // 6. Reset in the middle of a transaction
    $display("[TB] reset mid-transaction");
    doReset();
    setD(1'b0, 32'h500, 32'h0, 4'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    setI(1'b1, 32'h90, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    doReset();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 32'hABC);
      checkOutput("t6_idle_valid", {63'd0, memValid}, 64'd0);
      checkOutput("t6_no_iready", {63'd0, imemReady}, 64'd0);
      checkOutput("t6_no_dready", {63'd0, dmemReady}, 64'd0);
      tick();
    end
    setD(1'b0, 32'h600, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
    checkOutput("t6_tie_addr", {32'd0, memAddr}, 64'h600);
    checkOutput("t6_tie_instr", {63'd0, memInstr}, 64'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
    tick();

    // Randomized phase against the model
    $display("[TB] random phase");
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) != 0);
      setI(1'($urandom), $urandom, $urandom, 4'($urandom));
      setD(1'($urandom), $urandom, $urandom, 4'($urandom));
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                    rst && ($urandom_range(0, 2) != 0), $urandom);
      tick();
    end
    rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
